// File: rtl/mirfak_pkg.sv
// Shared constants for the Mirfak fetch slice: NOP encoding, reset PC default,
// fetch FSM state encodings and the redirect-target alignment helper.
package mirfak_pkg;

  localparam logic [31:0] MIRFAK_NOP        = 32'h0000_0013;
  localparam logic [31:0] MIRFAK_RESET_ADDR = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mirfak_ibuffer.sv
// One-entry holding register for a fetched instruction that decode could not
// accept. Clear wins over load, load wins over take.
module mirfak_ibuffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        take,
  input  logic [31:0] wr_data,
  input  logic [31:0] wr_pc,
  input  logic        wr_err,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        err,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= 32'h0;
      pc    <= 32'h0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= wr_data;
      pc    <= wr_pc;
      err   <= wr_err;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mirfak_fetch.sv
// Mirfak instruction fetch: PC generation, single-outstanding bus reads, stall
// buffering and redirects. MIRFAK_FETCH_MISALIGN_EN enables misaligned-target faults.
module mirfak_fetch
  import mirfak_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = MIRFAK_RESET_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        if_flush_i,
  input  logic [31:0] if_target_i,
  input  logic        id_stall_i,
  output logic [31:0] id_instruction_o,
  output logic [31:0] id_pc_o,
  output logic        id_valid_o,
  output logic        id_fetch_error_o,
  output logic        id_misaligned_o
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         drain_halt;
  logic [31:0]  tgt;
  logic         tgt_mis;
  logic         bus_done;
  logic [31:0]  rd_data;

  logic         buf_load, buf_clear, buf_take;
  logic [31:0]  buf_data, buf_pc;
  logic         buf_err, buf_valid;

`ifdef MIRFAK_FETCH_MISALIGN_EN
  assign tgt     = if_target_i;
  assign tgt_mis = |if_target_i[1:0];
`else
  assign tgt     = word_align(if_target_i);
  assign tgt_mis = 1'b0;
`endif

  assign iwbm_stb_o = iwbm_cyc_o;
  assign bus_done   = iwbm_cyc_o & (iwbm_ack_i | iwbm_err_i);
  // A faulted fetch is replaced by a NOP so decode never sees garbage bus data.
  assign rd_data    = iwbm_err_i ? MIRFAK_NOP : iwbm_dat_i;

  assign buf_clear = if_flush_i;
  assign buf_load  = !if_flush_i && (state == ST_REQ) && bus_done && id_stall_i;
  assign buf_take  = !if_flush_i && (state == ST_HOLD) && !id_stall_i;

  mirfak_ibuffer u_ibuf (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (buf_load),
    .clear   (buf_clear),
    .take    (buf_take),
    .wr_data (rd_data),
    .wr_pc   (pc),
    .wr_err  (iwbm_err_i),
    .data    (buf_data),
    .pc      (buf_pc),
    .err     (buf_err),
    .valid   (buf_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      pc               <= RESET_ADDR;
      drain_halt       <= 1'b0;
      iwbm_addr_o      <= RESET_ADDR;
      iwbm_cyc_o       <= 1'b0;
      id_instruction_o <= MIRFAK_NOP;
      id_pc_o          <= RESET_ADDR;
      id_valid_o       <= 1'b0;
      id_fetch_error_o <= 1'b0;
      id_misaligned_o  <= 1'b0;
    end else if (if_flush_i) begin
      pc               <= tgt;
      drain_halt       <= tgt_mis;
      id_valid_o       <= 1'b0;
      id_fetch_error_o <= 1'b0;
      id_misaligned_o  <= 1'b0;
      if (tgt_mis) begin
        id_instruction_o <= MIRFAK_NOP;
        id_pc_o          <= tgt;
        id_valid_o       <= 1'b1;
        id_misaligned_o  <= 1'b1;
      end
      // An unfinished cycle must run to completion; its result is dropped.
      if (iwbm_cyc_o && !bus_done) begin
        state <= ST_DRAIN;
      end else if (tgt_mis) begin
        state      <= ST_HALT;
        iwbm_cyc_o <= 1'b0;
      end else begin
        state       <= ST_REQ;
        iwbm_cyc_o  <= 1'b1;
        iwbm_addr_o <= tgt;
      end
    end else begin
      // Decode consumed whatever it was showing; overridden below on a new load.
      if (!id_stall_i) begin
        id_valid_o       <= 1'b0;
        id_fetch_error_o <= 1'b0;
        id_misaligned_o  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!id_stall_i) begin
            state       <= ST_REQ;
            iwbm_cyc_o  <= 1'b1;
            iwbm_addr_o <= pc;
          end
        end
        ST_REQ: begin
          if (bus_done) begin
            if (!iwbm_err_i) pc <= pc + 32'd4;
            if (id_stall_i) begin
              state      <= ST_HOLD;
              iwbm_cyc_o <= 1'b0;
            end else begin
              id_instruction_o <= rd_data;
              id_pc_o          <= pc;
              id_valid_o       <= 1'b1;
              id_fetch_error_o <= iwbm_err_i;
              if (iwbm_err_i) begin
                state      <= ST_HALT;
                iwbm_cyc_o <= 1'b0;
              end else begin
                iwbm_addr_o <= pc + 32'd4;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!id_stall_i) begin
            id_instruction_o <= buf_data;
            id_pc_o          <= buf_pc;
            id_valid_o       <= buf_valid;
            id_fetch_error_o <= buf_err;
            if (buf_err) begin
              state <= ST_HALT;
            end else begin
              state       <= ST_REQ;
              iwbm_cyc_o  <= 1'b1;
              iwbm_addr_o <= pc;
            end
          end
        end
        ST_DRAIN: begin
          if (bus_done) begin
            if (drain_halt) begin
              state      <= ST_HALT;
              iwbm_cyc_o <= 1'b0;
            end else begin
              state       <= ST_REQ;
              iwbm_addr_o <= pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
